conv_job_sequencer: RTL and testbench
=====================================

Name: conv_job_sequencer

Overview:
- Upstream front-end for the 8-bit binary/Gray conversion controller.
- Accepts conversion jobs on a valid/ready request port and buffers them in a small FIFO.
- Presents one job at a time to the controller (start/convert plus a stable operand) and waits for done.
- Captures the converted word and returns it on a valid/ready response port.

Parameters:
- DATA_W, 8, operand/result width.
- DEPTH, 2, request FIFO entries (power of 2, ≥2).
- TIMEOUT, 32, max WAIT cycles before fault (used only with the optional feature).

Ports:
- clk  in  1  single clock, posedge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  job offered.
- req_ready  out  1  job accepted when both high; = !fifo_full.
- req_data  in  DATA_W  operand.
- req_mode  in  1  0 = binary→Gray, 1 = Gray→binary.
- start  out  1  start request to the conversion controller.
- convert  out  1  mode of the active job, to the controller.
- dp_data  out  DATA_W  active operand, to the datapath R1 load.
- done  in  1  controller done level.
- result_in  in  DATA_W  converted word from the datapath; valid while done = 1.
- rsp_valid  out  1  response held.
- rsp_ready  in  1  response consumed when both high.
- rsp_data  out  DATA_W  converted word.
- rsp_mode  out  1  mode echoed from the job.
- rsp_err  out  1  timeout flag; constant 0 without the optional feature.
- busy  out  1  state ≠ IDLE or FIFO non-empty.

Behaviour:
- Reset values: state IDLE, FIFO empty, start 0, convert 0, dp_data 0, rsp_valid 0, rsp_data 0, rsp_mode 0, rsp_err 0, busy 0.
  - req_ready = 1, but pushes are ignored while rst is high.
- FIFO:
  - Push on req_valid && req_ready.
  - Pop only in IDLE.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Full: req_ready = 0. Pointers wrap modulo DEPTH.
- States:
  - IDLE:
    - If FIFO non-empty && !rsp_valid && !done: pop the head into job registers (dp_data, convert, mode) → ISSUE.
    - Otherwise stay.
  - ISSUE: start = 1 → WAIT.
  - WAIT:
    - start = 1.
    - On done = 1: rsp_data ← result_in, rsp_mode ← job mode, rsp_valid ← 1 at the same edge → RELEASE.
  - RELEASE:
    - start = 0.
    - When done = 0 → IDLE.
    - The controller drops done one cycle after start falls.
- start is a Moore decode of the state register (ISSUE or WAIT), glitch-free.
- dp_data and convert are stable from the pop edge until return to IDLE; they are not altered by new pushes.
- Response:
  - rsp_valid holds with data stable until rsp_ready.
  - Cleared at the edge where rsp_valid && rsp_ready.
  - rsp_ready while rsp_valid = 0 has no effect.
- Latency:
  - Push into an empty FIFO at edge e0 → pop at e1 → start high from e1 to the done edge.
  - rsp_valid rises at the edge where done is sampled high.
  - With rsp_ready held high, the next job pops at the earliest 2 cycles after done falls.
- No job issues while rsp_valid = 1; there is a single output slot, so back-pressure propagates to the FIFO, then to req_ready.
- done high in IDLE/ISSUE is ignored.
- Reset mid-job: everything returns to reset values and the in-flight job is discarded; start falls asynchronously.

Optional Feature:
- Macro: CONV_SEQ_WATCHDOG_EN.
- Defined:
  - Cycle counter runs in WAIT and clears on entry.
  - If the count reaches TIMEOUT with no done: rsp_valid = 1, rsp_err = 1, rsp_data = 0, start = 0 → state FAULT.
  - FAULT is sticky until rst: req_ready = 0, no pops, busy = 1.
- Undefined: no counter and no FAULT state; rsp_err tied 0; WAIT waits forever.

Decomposition:
- Package conv_seq_pkg holds:
  - state encoding: IDLE, ISSUE, WAIT, RELEASE, FAULT;
  - DATA_W default;
  - MODE_B2G = 0 and MODE_G2B = 1 constants.
- One sub-module, conv_req_fifo: parameterised DEPTH × (DATA_W+1) synchronous FIFO with full/empty, async reset.
- The sequencer FSM and response register stay in the top module.

Test Plan:
- Single job: req 0xB5, mode 0; controller model asserts done with result_in 0xEF → rsp_data 0xEF, rsp_mode 0, rsp_err 0; start low within 1 cycle after done is sampled.
- Reverse mode: req 0xEF, mode 1, model returns 0xB5 → rsp_data 0xB5, rsp_mode 1; dp_data = 0xEF and convert = 1 stable throughout ISSUE..RELEASE.
- Back-pressure: rsp_ready = 0; push 0x01, 0x02, 0x03 (DEPTH 2) → first job completes and holds; FIFO fills, req_ready = 0. Release rsp_ready → responses come out in order with no loss or duplication.
- Handshake timing: controller model holds done until start drops → sequencer stays in RELEASE while done = 1; no second start until done = 0; done pulses during IDLE are ignored.
- Reset mid-job: assert rst during WAIT → start, rsp_valid, busy = 0 immediately; FIFO empty; a new job 0x00 afterwards completes with 0x00.
- With CONV_SEQ_WATCHDOG_EN, TIMEOUT = 32: done never asserted → at cycle 32 of WAIT, rsp_valid = 1, rsp_err = 1, rsp_data = 0x00; afterwards req_ready stays 0 until rst.

Source files
------------

// File: rtl/conv_seq_pkg.sv
// conv_seq_pkg: shared definitions for the conversion job sequencer slice.
//   - seq_state_e : sequencer FSM state encoding (ST_FAULT exists only when
//                   CONV_SEQ_WATCHDOG_EN is defined)
//   - DATA_W_DEF  : default operand/result width
//   - MODE_B2G / MODE_G2B : job mode encodings (binary->Gray, Gray->binary)
package conv_seq_pkg;

    localparam int unsigned DATA_W_DEF = 8;

    localparam logic MODE_B2G = 1'b0;
    localparam logic MODE_G2B = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RELEASE
`ifdef CONV_SEQ_WATCHDOG_EN
        , ST_FAULT
`endif
    } seq_state_e;

endpackage

// File: rtl/conv_job_sequencer_if.sv
// conv_job_sequencer_if: request/response handshake bundle of the sequencer.
//   Request : req_valid, req_ready, req_data[DATA_W], req_mode
//   Response: rsp_valid, rsp_ready, rsp_data[DATA_W], rsp_mode, rsp_err
//   modport master : job producer / response consumer
//   modport slave  : the sequencer
interface conv_job_sequencer_if #(
    parameter int unsigned DATA_W = conv_seq_pkg::DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [DATA_W-1:0] req_data;
    logic              req_mode;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_mode;
    logic              rsp_err;

    modport master (
        output req_valid, req_data, req_mode, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_mode, rsp_err
    );

    modport slave (
        input  req_valid, req_data, req_mode, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_mode, rsp_err
    );

endinterface

// File: rtl/conv_req_fifo.sv
// conv_req_fifo: DEPTH x WIDTH synchronous request FIFO, async active-high reset.
//   clk, rst        : clock, asynchronous reset
//   push, wr_data   : write strobe and word (ignored when full)
//   pop             : advance head (ignored when empty)
//   rd_data         : current head word (valid when !empty)
//   full, empty     : occupancy flags
// DEPTH must be a power of two so the pointers wrap naturally.
module conv_req_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            mem    <= '{default: '0};
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!do_push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == DEPTH_CNT);
    assign empty   = (count == '0);

endmodule

// File: rtl/conv_job_sequencer.sv
// conv_job_sequencer: front-end for the 8-bit binary/Gray conversion controller.
// Buffers jobs in a request FIFO, issues them one at a time to the controller
// (start/convert/dp_data), waits for done, captures result_in into a single
// response slot and returns it on the response handshake.
//   clk, rst   : clock, asynchronous active-high reset
//   bus        : conv_job_sequencer_if.slave (request + response handshakes)
//   start      : start request to the controller (high in ISSUE and WAIT)
//   convert    : mode of the active job
//   dp_data    : operand of the active job, stable until back in IDLE
//   done       : controller done level
//   result_in  : converted word, valid while done = 1
//   busy       : FSM not idle or jobs queued
// Optional build macro CONV_SEQ_WATCHDOG_EN adds a WAIT timeout (TIMEOUT cycles)
// that raises rsp_err and parks the FSM in a sticky FAULT state.
module conv_job_sequencer
    import conv_seq_pkg::*;
#(
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned DEPTH   = 2
`ifdef CONV_SEQ_WATCHDOG_EN
    , parameter int unsigned TIMEOUT = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    conv_job_sequencer_if.slave bus,
    output logic                start,
    output logic                convert,
    output logic [DATA_W-1:0]   dp_data,
    input  logic                done,
    input  logic [DATA_W-1:0]   result_in,
    output logic                busy
);

    seq_state_e      state;
    seq_state_e      state_nxt;
    logic            push;
    logic            pop;
    logic            capture;
    logic            fifo_full;
    logic            fifo_empty;
    logic [DATA_W:0] head;

`ifdef CONV_SEQ_WATCHDOG_EN
    localparam int unsigned CW      = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WD_LAST = CW'(TIMEOUT - 1);
    logic [CW-1:0] wd_cnt;
    logic          fault_set;
`endif

    conv_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data ({bus.req_mode, bus.req_data}),
        .pop     (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

`ifdef CONV_SEQ_WATCHDOG_EN
    assign bus.req_ready = !fifo_full && (state != ST_FAULT);
`else
    assign bus.req_ready = !fifo_full;
`endif
    assign push  = bus.req_valid && bus.req_ready;
    assign start = (state == ST_ISSUE) || (state == ST_WAIT);
    assign busy  = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        capture   = 1'b0;
`ifdef CONV_SEQ_WATCHDOG_EN
        fault_set = 1'b0;
`endif
        case (state)
            ST_IDLE: begin
                // A held response or a lingering done blocks the next issue.
                if (!fifo_empty && !bus.rsp_valid && !done) begin
                    pop       = 1'b1;
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    capture   = 1'b1;
                    state_nxt = ST_RELEASE;
                end
`ifdef CONV_SEQ_WATCHDOG_EN
                else if (wd_cnt == WD_LAST) begin
                    fault_set = 1'b1;
                    state_nxt = ST_FAULT;
                end
`endif
            end
            ST_RELEASE: begin
                if (!done) begin
                    state_nxt = ST_IDLE;
                end
            end
`ifdef CONV_SEQ_WATCHDOG_EN
            ST_FAULT: begin
                state_nxt = ST_FAULT;
            end
`endif
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job registers load only on pop, so queued pushes never disturb the
    // operand presented to the controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_data       <= '0;
            convert       <= MODE_B2G;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_mode  <= MODE_B2G;
        end else begin
            if (pop) begin
                dp_data <= head[DATA_W-1:0];
                convert <= head[DATA_W];
            end
            if (capture) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= result_in;
                bus.rsp_mode  <= convert;
            end
`ifdef CONV_SEQ_WATCHDOG_EN
            else if (fault_set) begin
                bus.rsp_valid <= 1'b1;
                bus.rsp_data  <= '0;
                bus.rsp_mode  <= convert;
            end
`endif
            else if (bus.rsp_valid && bus.rsp_ready) begin
                bus.rsp_valid <= 1'b0;
            end
        end
    end

`ifdef CONV_SEQ_WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt      <= '0;
            bus.rsp_err <= 1'b0;
        end else begin
            if (state == ST_ISSUE) begin
                wd_cnt <= '0;
            end else if (state == ST_WAIT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
            if (capture) begin
                bus.rsp_err <= 1'b0;
            end else if (fault_set) begin
                bus.rsp_err <= 1'b1;
            end else if (bus.rsp_valid && bus.rsp_ready) begin
                bus.rsp_err <= 1'b0;
            end
        end
    end
`else
    assign bus.rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_conv_job_sequencer.sv
// tb_conv_job_sequencer: directed bench for conv_job_sequencer (default build).
// A behavioural controller answers start with done/result_in; a job-level
// scoreboard checks ordering, handshakes and flags every cycle, and directed
// phases pin hand-computed literal results.
module tb_conv_job_sequencer;
    import conv_seq_pkg::*;

    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [7:0] d;
        logic       m;
    } job_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       convert;
    logic [7:0] dp_data;
    logic       done;
    logic       done_ctl;
    logic       done_glitch;
    logic [7:0] result_in;
    logic       busy;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    int unsigned ctl_lat    = 2;
    int unsigned hold_extra = 0;
    int unsigned ctl_cnt;
    int unsigned hold_cnt;

    conv_job_sequencer_if #(.DATA_W(8)) bus ();

    conv_job_sequencer #(
        .DATA_W (8),
        .DEPTH  (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .start     (start),
        .convert   (convert),
        .dp_data   (dp_data),
        .done      (done),
        .result_in (result_in),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    assign done = done_ctl | done_glitch;

    function automatic logic [7:0] model_conv(input logic [7:0] x, input logic m);
        logic [7:0] y;
        if (m == MODE_B2G) begin
            y = x ^ (x >> 1);
        end else begin
            y[7] = x[7];
            for (int i = 6; i >= 0; i--) y[i] = y[i+1] ^ x[i];
        end
        return y;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Controller: done after ctl_lat cycles of start, held until start drops
    // plus hold_extra cycles.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            done_ctl  <= 1'b0;
            result_in <= 8'h00;
            ctl_cnt   <= 0;
            hold_cnt  <= 0;
        end else if (!done_ctl) begin
            if (start) begin
                if (ctl_cnt >= ctl_lat) begin
                    done_ctl  <= 1'b1;
                    result_in <= model_conv(dp_data, convert);
                    ctl_cnt   <= 0;
                end else begin
                    ctl_cnt <= ctl_cnt + 1;
                end
            end
        end else if (!start) begin
            if (hold_cnt >= hold_extra) begin
                done_ctl <= 1'b0;
                hold_cnt <= 0;
            end else begin
                hold_cnt <= hold_cnt + 1;
            end
        end
    end

    // Job-level scoreboard, sampled on the falling edge.
    job_t       pending[$];
    job_t       exp_rsp[$];
    job_t       cur;
    job_t       push_item_q;
    logic       in_flight = 1'b0;
    logic       rel = 1'b0;
    logic       push_q = 1'b0;
    logic       cons_q = 1'b0;
    logic       start_q = 1'b0;
    logic       done_q = 1'b0;
    logic       rv_q = 1'b0;
    logic [7:0] rd_q = 8'h00;
    logic       rm_q = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pending.delete();
                exp_rsp.delete();
                in_flight = 1'b0;
                rel       = 1'b0;
                push_q    = 1'b0;
                cons_q    = 1'b0;
                start_q   = 1'b0;
                rv_q      = 1'b0;
                done_q    = done;
            end else begin
                if (push_q) pending.push_back(push_item_q);
                if (rel && !done_q) begin
                    rel       = 1'b0;
                    in_flight = 1'b0;
                end
                if (in_flight && start_q && !start) begin
                    rel = 1'b1;
                    exp_rsp.push_back('{d: model_conv(cur.d, cur.m), m: cur.m});
                end
                if (start && !start_q) begin
                    chk("issue_has_job", 32'(pending.size() != 0), 1);
                    chk("issue_done_low", done_q, 0);
                    chk("issue_no_rsp_held", rv_q, 0);
                    if (pending.size() != 0) cur = pending.pop_front();
                    in_flight = 1'b1;
                end
                if (in_flight) begin
                    chk("job_dp_data", dp_data, cur.d);
                    chk("job_convert", convert, cur.m);
                end
                if (bus.rsp_valid && !rv_q) chk("rsp_rise_at_start_fall", start_q && !start, 1);
                if (rv_q && !cons_q) begin
                    chk("rsp_hold_valid", bus.rsp_valid, 1);
                    chk("rsp_hold_data", bus.rsp_data, rd_q);
                    chk("rsp_hold_mode", bus.rsp_mode, rm_q);
                end
                if (bus.rsp_valid && bus.rsp_ready) begin
                    chk("rsp_expected", 32'(exp_rsp.size() != 0), 1);
                    if (exp_rsp.size() != 0) begin
                        chk("rsp_data", bus.rsp_data, exp_rsp[0].d);
                        chk("rsp_mode", bus.rsp_mode, exp_rsp[0].m);
                        void'(exp_rsp.pop_front());
                    end
                end
                chk("req_ready", bus.req_ready, 32'(pending.size() < DEPTH));
                chk("busy", busy, 32'(pending.size() != 0 || in_flight));
                chk("rsp_err", bus.rsp_err, 0);
                chk("start_vs_rsp_valid", start && bus.rsp_valid, 0);
                push_q      = bus.req_valid && bus.req_ready;
                push_item_q = '{d: bus.req_data, m: bus.req_mode};
                cons_q      = bus.rsp_valid && bus.rsp_ready;
                start_q     = start;
                done_q      = done;
                rv_q        = bus.rsp_valid;
                rd_q        = bus.rsp_data;
                rm_q        = bus.rsp_mode;
            end
        end
    end

    task automatic push_job(input logic [7:0] d, input logic m);
        int unsigned n = 0;
        bus.req_valid = 1'b1;
        bus.req_data  = d;
        bus.req_mode  = m;
        @(negedge clk);
        while (!bus.req_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("push_accept", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string name);
        int unsigned n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk(name, bus.rsp_valid, 1);
    endtask

    task automatic wait_idle();
        int unsigned n = 0;
        @(negedge clk);
        while ((busy || bus.rsp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", busy || bus.rsp_valid, 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout at %0t", $time);
        $fatal(1, "bench time limit");
    end

    initial begin
        logic [7:0] bp_exp [3];
        rst           = 1'b1;
        done_glitch   = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'h00;
        bus.req_mode  = MODE_B2G;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_start", start, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_dp_data", dp_data, 8'h00);
        chk("rst_convert", convert, 0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        chk("rst_rsp_mode", bus.rsp_mode, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single job with latency pinned: push at e0, pop at e1.
        bus.req_valid = 1'b1;
        bus.req_data  = 8'hB5;
        bus.req_mode  = MODE_B2G;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        chk("t1_start_before_pop", start, 0);
        chk("t1_busy_queued", busy, 1);
        @(posedge clk);
        #1;
        chk("t1_start_after_pop", start, 1);
        chk("t1_dp_data", dp_data, 8'hB5);
        wait_rsp("t1_rsp_timeout");
        chk("t1_rsp_data", bus.rsp_data, 8'hEF);
        chk("t1_rsp_mode", bus.rsp_mode, 0);
        chk("t1_rsp_err", bus.rsp_err, 0);
        chk("t1_start_low", start, 0);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_idle();

        // Reverse mode.
        push_job(8'hEF, MODE_G2B);
        wait_rsp("t2_rsp_timeout");
        chk("t2_rsp_data", bus.rsp_data, 8'hB5);
        chk("t2_rsp_mode", bus.rsp_mode, 1);
        wait_idle();

        // Back-pressure through the single response slot into the FIFO.
        bus.rsp_ready = 1'b0;
        push_job(8'h01, MODE_B2G);
        push_job(8'h02, MODE_B2G);
        push_job(8'h03, MODE_B2G);
        wait_rsp("t3_first_timeout");
        repeat (3) @(negedge clk);
        chk("t3_req_ready_full", bus.req_ready, 0);
        chk("t3_held_data", bus.rsp_data, 8'h01);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        bp_exp[0] = 8'h01;
        bp_exp[1] = 8'h03;
        bp_exp[2] = 8'h02;
        for (int i = 0; i < 3; i++) begin
            wait_rsp("t3_rsp_timeout");
            chk("t3_order", bus.rsp_data, bp_exp[i]);
            @(posedge clk);
            #1;
        end
        wait_idle();

        // Controller keeps done high after start drops: no new start meanwhile.
        hold_extra = 3;
        push_job(8'h10, MODE_B2G);
        push_job(8'h20, MODE_G2B);
        wait_rsp("t4_first_timeout");
        chk("t4_first_data", bus.rsp_data, 8'h18);
        repeat (4) begin
            @(negedge clk);
            chk("t4_no_start_while_done", start, 0);
        end
        wait_rsp("t4_second_timeout");
        chk("t4_second_data", bus.rsp_data, 8'h3F);
        chk("t4_second_mode", bus.rsp_mode, 1);
        hold_extra = 0;
        wait_idle();

        // done high in IDLE is ignored and blocks issue.
        done_glitch = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("t5_glitch_no_rsp", bus.rsp_valid, 0);
            chk("t5_glitch_no_busy", busy, 0);
        end
        @(posedge clk);
        #1;
        push_job(8'h5A, MODE_B2G);
        repeat (3) begin
            @(negedge clk);
            chk("t5_blocked_start", start, 0);
        end
        @(posedge clk);
        #1;
        done_glitch = 1'b0;
        wait_rsp("t5_rsp_timeout");
        chk("t5_rsp_data", bus.rsp_data, 8'h77);
        wait_idle();

        // Reset during WAIT discards the job.
        ctl_lat = 10;
        push_job(8'hC3, MODE_G2B);
        repeat (4) @(posedge clk);
        #2;
        chk("t6_in_wait", start, 1);
        rst           = 1'b1;
        bus.req_valid = 1'b1;
        bus.req_data  = 8'h99;
        bus.req_mode  = MODE_B2G;
        #1;
        chk("t6_rst_start", start, 0);
        chk("t6_rst_rsp_valid", bus.rsp_valid, 0);
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_req_ready", bus.req_ready, 1);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        rst           = 1'b0;
        ctl_lat       = 2;
        @(negedge clk);
        chk("t6_fifo_empty", busy, 0);
        @(posedge clk);
        #1;
        push_job(8'h00, MODE_B2G);
        wait_rsp("t6_rsp_timeout");
        chk("t6_rsp_data", bus.rsp_data, 8'h00);
        chk("t6_rsp_mode", bus.rsp_mode, 0);
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
